// File: rtl/dram_sched_pkg.sv
// Shared types and helpers for the DRAM frame scheduler: FSM states,
// per-buffer ownership states and frame-size / buffer-address helpers.
package dram_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_DROP  = 3'd4
    } fsm_t;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } buf_st_t;

    localparam int unsigned BURST_BYTES = 128;

    // Buffer start address, wrapping modulo 2^32.
    function automatic logic [31:0] buf_addr(input logic [31:0] base,
                                             input logic [31:0] idx,
                                             input logic [31:0] stride);
        return base + (idx * stride);
    endfunction

    // A frame must be a non-zero whole number of write bursts.
    function automatic logic size_bad(input logic [31:0] nbytes);
        return (nbytes == 32'd0) ||
               ((nbytes & (32'(BURST_BYTES) - 32'd1)) != 32'd0);
    endfunction

endpackage

// File: rtl/dram_buf_pool.sv
// Ownership state of every frame buffer, plus the lowest-free and
// current-FULL lookups the scheduler needs to make its decisions.
module dram_buf_pool
    import dram_sched_pkg::*;
#(
    parameter int NBUF  = 3,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_alloc,
    input  logic             i_complete,
    input  logic             i_acquire,
    input  logic             i_release,
    output logic             o_free_any,
    output logic [IDX_W-1:0] o_free_idx,
    output logic             o_full_any,
    output logic [IDX_W-1:0] o_full_idx
);

    buf_st_t r_st   [NBUF];
    buf_st_t w_st_nx[NBUF];

    // Lookups; scanning downward lets the lowest free index win.
    always_comb begin
        o_free_any = 1'b0;
        o_free_idx = '0;
        o_full_any = 1'b0;
        o_full_idx = '0;
        for (int i = NBUF - 1; i >= 0; i--) begin
            o_free_any = o_free_any | (r_st[i] == FREE);
            o_free_idx = (r_st[i] == FREE) ? IDX_W'(i) : o_free_idx;
            o_full_any = o_full_any | (r_st[i] == FULL);
            o_full_idx = (r_st[i] == FULL) ? IDX_W'(i) : o_full_idx;
        end
    end

    // Per-entry transitions; an acquire of the old FULL beats its retirement.
    always_comb begin
        for (int i = 0; i < NBUF; i++) begin
            w_st_nx[i] = r_st[i];
            case (r_st[i])
                FREE: begin
                    if (i_alloc && (o_free_idx == IDX_W'(i))) w_st_nx[i] = WRITING;
                    else                                      w_st_nx[i] = FREE;
                end
                WRITING: begin
                    if (i_complete) w_st_nx[i] = FULL;
                    else            w_st_nx[i] = WRITING;
                end
                FULL: begin
                    if (i_acquire)       w_st_nx[i] = READING;
                    else if (i_complete) w_st_nx[i] = FREE;
                    else                 w_st_nx[i] = FULL;
                end
                READING: begin
                    if (i_release) w_st_nx[i] = FREE;
                    else           w_st_nx[i] = READING;
                end
                default: w_st_nx[i] = FREE;
            endcase
        end
    end

    // State array register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBUF; i++) begin
            if (!rst_n) r_st[i] <= FREE;
            else        r_st[i] <= w_st_nx[i];
        end
    end

endmodule

// File: rtl/dram_frame_scheduler.sv
// Frame scheduler for the AXI burst DRAM writer: hands each incoming frame
// a free buffer, tracks completion and lends the newest frame to one reader.
module dram_frame_scheduler
    import dram_sched_pkg::*;
#(
    parameter int          NBUF   = 3,
    parameter logic [31:0] STRIDE = 32'h0020_0000,
    parameter int          CNT_W  = 16
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             ENABLE,
    input  logic [31:0]      CFG_BASE_ADDR,
    input  logic [31:0]      CFG_FRAME_BYTES,
    input  logic             FRAME_START,
    output logic             DROP,
    output logic             WR_CONFIG_VALID,
    input  logic             WR_CONFIG_READY,
    output logic [31:0]      WR_START_ADDR,
    output logic [31:0]      WR_NBYTES,
    input  logic             RD_ACQUIRE,
    output logic             RD_VALID,
    output logic [31:0]      RD_ADDR,
    input  logic             RD_RELEASE,
    output logic             BUSY,
    output logic             ERR_CFG,
    output logic [CNT_W-1:0] DROP_COUNT
);

    localparam int IDX_W = (NBUF > 1) ? $clog2(NBUF) : 1;

    fsm_t             r_state;
    fsm_t             w_next;
    logic             w_start;
    logic             w_alloc;
    logic             w_complete;
    logic             w_acquire;
    logic             w_release;
    logic             w_drop_inc;
    logic             w_err_set;
    logic             w_free_any;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_full_any;
    logic [IDX_W-1:0] w_full_idx;

    logic             r_cfg_valid;
    logic             r_busy;
    logic             r_drop;
    logic             r_err;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_wr_nbytes;
    logic [31:0]      r_full_addr;
    logic             r_rd_valid;
    logic [31:0]      r_rd_addr;

    assign w_start   = FRAME_START & ENABLE;
    assign w_acquire = RD_ACQUIRE & w_full_any & ~r_rd_valid;
    assign w_release = RD_RELEASE & r_rd_valid;

    dram_buf_pool #(
        .NBUF  (NBUF),
        .IDX_W (IDX_W)
    ) u_pool (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .i_alloc    (w_alloc),
        .i_complete (w_complete),
        .i_acquire  (w_acquire),
        .i_release  (w_release),
        .o_free_any (w_free_any),
        .o_free_idx (w_free_idx),
        .o_full_any (w_full_any),
        .o_full_idx (w_full_idx)
    );

    // Next-state logic; S_DROP re-evaluates a start exactly like S_IDLE.
    always_comb begin
        w_next     = r_state;
        w_alloc    = 1'b0;
        w_complete = 1'b0;
        w_drop_inc = 1'b0;
        w_err_set  = 1'b0;
        case (r_state)
            S_IDLE, S_DROP: begin
                if ((r_state == S_DROP) && !ENABLE) begin
                    w_next = S_IDLE;
                end else if (w_start) begin
                    if (size_bad(CFG_FRAME_BYTES)) begin
                        w_err_set = 1'b1;
                        w_next    = S_DROP;
                    end else if (w_free_any) begin
                        w_alloc = 1'b1;
                        w_next  = S_ISSUE;
                    end else begin
                        w_drop_inc = 1'b1;
                        w_next     = S_DROP;
                    end
                end else begin
                    w_next = r_state;
                end
            end
            S_ISSUE: begin
                w_drop_inc = w_start;
                w_next     = WR_CONFIG_READY ? S_ARM : S_ISSUE;
            end
            S_ARM: begin
                w_drop_inc = w_start;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                w_drop_inc = w_start;
                if (WR_CONFIG_READY) begin
                    w_complete = 1'b1;
                    w_next     = S_IDLE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Writer-side outputs and status, registered from the next state.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_cfg_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_drop      <= 1'b0;
            r_err       <= 1'b0;
            r_drop_cnt  <= '0;
            r_wr_addr   <= 32'd0;
            r_wr_nbytes <= 32'd0;
        end else begin
            r_cfg_valid <= (w_next == S_ISSUE);
            r_busy      <= (w_next == S_ISSUE) || (w_next == S_ARM) || (w_next == S_WAIT);
            r_drop      <= (w_next == S_DROP);
            r_err       <= r_err | w_err_set;
            if (w_drop_inc && (r_drop_cnt != {CNT_W{1'b1}})) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            else                                              r_drop_cnt <= r_drop_cnt;
            if (w_alloc) begin
                r_wr_addr   <= buf_addr(CFG_BASE_ADDR, 32'(w_free_idx), STRIDE);
                r_wr_nbytes <= CFG_FRAME_BYTES;
            end else begin
                r_wr_addr   <= r_wr_addr;
                r_wr_nbytes <= r_wr_nbytes;
            end
        end
    end

    // Reader hand-off; acquire sees the FULL address from before this edge.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_full_addr <= 32'd0;
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= 32'd0;
        end else begin
            if (w_complete) r_full_addr <= r_wr_addr;
            else            r_full_addr <= r_full_addr;
            if (w_acquire) begin
                r_rd_valid <= 1'b1;
                r_rd_addr  <= r_full_addr;
            end else if (w_release) begin
                r_rd_valid <= 1'b0;
                r_rd_addr  <= r_rd_addr;
            end else begin
                r_rd_valid <= r_rd_valid;
                r_rd_addr  <= r_rd_addr;
            end
        end
    end

    // w_full_idx is consumed inside the pool; the address copy lives here.
    logic w_unused;
    assign w_unused = ^w_full_idx;

    assign WR_CONFIG_VALID = r_cfg_valid;
    assign WR_START_ADDR   = r_wr_addr;
    assign WR_NBYTES       = r_wr_nbytes;
    assign BUSY            = r_busy;
    assign DROP            = r_drop;
    assign ERR_CFG         = r_err;
    assign DROP_COUNT      = r_drop_cnt;
    assign RD_VALID        = r_rd_valid;
    assign RD_ADDR         = r_rd_addr;

endmodule
